// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - shared types and constants for the APB machine timer
package apb_timer_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_STATUS      = 5'h14;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Merge write data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_timer_core.sv
// rtl/apb_timer_core.sv - prescaler, 64-bit mtime counter, compare and registered irq
module apb_timer_core #(
  parameter int unsigned DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq_en,
  input  logic        mtime_we_lo,
  input  logic        mtime_we_hi,
  input  logic [31:0] mtime_wdata,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        cmp_hit,
  output logic        irq
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick    = enable && (presc == PRESC_LAST);
  assign cmp_hit = (mtime >= mtimecmp);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // A software write to either half takes priority; the coincident tick is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime <= '0;
    end else if (mtime_we_lo) begin
      mtime[31:0] <= mtime_wdata;
    end else if (mtime_we_hi) begin
      mtime[63:32] <= mtime_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && cmp_hit;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB completer with wait states around a 64-bit machine timer
// Optional APB_TIMER_SNAPSHOT_EN: reading MTIME_LO latches mtime[63:32] for the next MTIME_HI read.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DIV         = 1,
  parameter logic [31:0] BASE_MASK   = 32'h0000_001F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic [2:0]  pprot,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        irq
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_n;
  logic [3:0]  count, count_n;
  logic        capture, commit;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [4:0]  sel_q;
  logic        write_q;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [1:0]  ctrl;
  logic        cmp_hit;
  logic [31:0] mtime_hi_view;
  logic [31:0] rd_mux;
  logic [31:0] offset;
  logic [4:0]  reg_sel;
  logic        addr_err;
  logic        unused_pprot;

  assign unused_pprot = ^pprot;

  assign offset   = paddr & BASE_MASK;
  assign reg_sel  = offset[4:0];
  assign addr_err = (paddr[1:0] != 2'b00) || (offset > 32'h14) ||
                    (pwrite && (reg_sel == OFF_STATUS));

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      OFF_MTIME_LO:    rd_mux = mtime[31:0];
      OFF_MTIME_HI:    rd_mux = mtime_hi_view;
      OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      OFF_CTRL:        rd_mux = {30'b0, ctrl};
      OFF_STATUS:      rd_mux = {31'b0, cmp_hit};
      default:         rd_mux = '0;
    endcase
  end

`ifdef APB_TIMER_SNAPSHOT_EN
  logic [31:0] mtime_shadow;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_shadow <= '0;
    end else if (capture && !pwrite && !addr_err && (reg_sel == OFF_MTIME_LO)) begin
      mtime_shadow <= mtime[63:32];
    end
  end

  assign mtime_hi_view = mtime_shadow;
`else
  assign mtime_hi_view = mtime[63:32];
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    capture = 1'b0;
    commit  = 1'b0;
    pready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          count_n = WAIT_INIT;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        pready = (count == 4'd0);
        if (!psel) begin
          state_n = S_IDLE;
        end else if (count != 4'd0) begin
          count_n = count - 4'd1;
        end else begin
          commit  = write_q && !err_q;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (capture) begin
        rdata_q <= (addr_err || pwrite) ? '0 : rd_mux;
        err_q   <= addr_err;
        sel_q   <= reg_sel;
        write_q <= pwrite;
      end
    end
  end

  assign prdata  = pready ? rdata_q : '0;
  assign pslverr = pready && err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtimecmp <= MTIMECMP_RESET;
      ctrl     <= '0;
    end else if (commit) begin
      case (sel_q)
        OFF_MTIMECMP_LO: mtimecmp[31:0]  <= apply_strb(mtimecmp[31:0], pwdata, pstrb);
        OFF_MTIMECMP_HI: mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], pwdata, pstrb);
        OFF_CTRL:        if (pstrb[0]) ctrl <= pwdata[1:0];
        default:         ;
      endcase
    end
  end

  logic        mtime_we_lo, mtime_we_hi;
  logic [31:0] mtime_wdata;

  assign mtime_we_lo = commit && (sel_q == OFF_MTIME_LO);
  assign mtime_we_hi = commit && (sel_q == OFF_MTIME_HI);
  assign mtime_wdata = apply_strb((sel_q == OFF_MTIME_HI) ? mtime[63:32] : mtime[31:0],
                                  pwdata, pstrb);

  apb_timer_core #(
    .DIV(DIV)
  ) u_core (
    .clock       (clock),
    .reset       (reset),
    .enable      (ctrl[CTRL_ENABLE]),
    .irq_en      (ctrl[CTRL_IRQ_EN]),
    .mtime_we_lo (mtime_we_lo),
    .mtime_we_hi (mtime_we_hi),
    .mtime_wdata (mtime_wdata),
    .mtimecmp    (mtimecmp),
    .mtime       (mtime),
    .cmp_hit     (cmp_hit),
    .irq         (irq)
  );

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - directed vector bench for apb_timer (WAIT_CYCLES=2, DIV=4)
module tb_apb_timer;

  logic        clock;
  logic        reset;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_timer #(
    .WAIT_CYCLES(2),
    .DIV(4),
    .BASE_MASK(32'h0000_001F)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pprot   (pprot),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full APB transfer; every transfer must complete on its 3rd ACCESS cycle.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    int ncyc;
    @(posedge clock); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; psel = 1'b1; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1;
    ncyc = 0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      ncyc++;
      if (pready) begin
        rdata = prdata;
        err   = pslverr;
        break;
      end
    end
    check("latency", 64'(ncyc), 64'd3);
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        e;
    xfer(addr, 1'b1, data, 4'hF, rd, e);
    check("write_err", 64'(e), 64'd0);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    xfer(addr, 1'b0, 32'h0, 4'h0, rd, e);
    check(name, {32'h0, rd}, {32'h0, exp});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          rise;

    reset = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pprot = '0;
    pwrite = 1'b0; pwdata = '0; pstrb = '0;

    vecs[0]  = '{32'h08, 1'b0, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{32'h0C, 1'b0, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h00, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[3]  = '{32'h10, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[4]  = '{32'h02, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[5]  = '{32'h18, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[6]  = '{32'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[7]  = '{32'h14, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[8]  = '{32'h0A, 1'b1, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[9]  = '{32'h08, 1'b0, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{32'h08, 1'b1, 32'h0000_AB00, 4'h2, 32'h0,         1'b0};
    vecs[11] = '{32'h08, 1'b0, 32'h0,         4'h0, 32'hFFFF_ABFF, 1'b0};
    vecs[12] = '{32'h10, 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0,         1'b0};
    vecs[13] = '{32'h10, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[14] = '{32'h0C, 1'b1, 32'h1234_5678, 4'h9, 32'h0,         1'b0};
    vecs[15] = '{32'h0C, 1'b0, 32'h0,         4'h0, 32'h12FF_FF78, 1'b0};
    vecs[16] = '{32'h20, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[17] = '{32'h1C, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};

    #1;
    check("rst_pready0", 64'(pready), 64'd0);
    check("rst_prdata0", 64'(prdata), 64'd0);
    check("rst_pslverr0", 64'(pslverr), 64'd0);
    check("rst_irq0", 64'(irq), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, rd, e);
      check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), {32'h0, rd}, {32'h0, vecs[i].exp_rdata});
    end

    // Prescaled counting: 41 enabled clocks before the read's setup sample -> mtime 10.
    do_reset();
    wr32(32'h10, 32'h3);
    repeat (40) @(posedge clock);
    rd_check("mtime_div4", 32'h00, 32'd10);

    // irq rises one cycle after mtime reaches mtimecmp, drops one cycle after raising cmp.
    do_reset();
    wr32(32'h0C, 32'h0);
    wr32(32'h08, 32'h5);
    wr32(32'h10, 32'h3);
    rise = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock); #1;
      if (irq && rise == 0) rise = i;
    end
    check("irq_rise_cycle", 64'(rise), 64'd21);
    wr32(32'h08, 32'd100);
    check("irq_before_drop", 64'(irq), 64'd1);
    @(posedge clock); #1;
    check("irq_dropped", 64'(irq), 64'd0);

    // 64-bit wrap with mtimecmp = 10.
    do_reset();
    wr32(32'h08, 32'd10);
    wr32(32'h0C, 32'h0);
    wr32(32'h00, 32'hFFFF_FFFF);
    wr32(32'h04, 32'hFFFF_FFFF);
    rd_check("status_prewrap", 32'h14, 32'h1);
    rd_check("mtime_hi_max", 32'h04, 32'hFFFF_FFFF);
    wr32(32'h10, 32'h1);
    repeat (6) @(posedge clock);
    rd_check("status_postwrap", 32'h14, 32'h0);
    rd_check("mtime_lo_postwrap", 32'h00, 32'd2);
    rd_check("mtime_hi_postwrap", 32'h04, 32'h0);

    // psel dropped during ACCESS: no commit.
    @(posedge clock); #1;
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h55; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1;
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd_check("abort_no_commit", 32'h08, 32'd10);

    // Reset asserted in ACCESS of a write.
    @(posedge clock); #1;
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h1234_5678; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("midrst_pready", 64'(pready), 64'd0);
    check("midrst_prdata", 64'(prdata), 64'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    rd_check("midrst_cmp_lo", 32'h08, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
